// File: rtl/limber_gnrl_fifo.sv
// limber_gnrl_fifo: valid/ready FIFO of DP words, one-cycle latency, any depth, optional output masking while empty
module limber_gnrl_fifo #(
  parameter int DW   = 8,
  parameter int DP   = 4,
  parameter bit MSKO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_vld,
  output logic                     i_rdy,
  input  logic [DW-1:0]            i_dat,
  output logic                     o_vld,
  input  logic                     o_rdy,
  output logic [DW-1:0]            o_dat,
  output logic [$clog2(DP+1)-1:0]  cnt
);
  localparam int PW = DP > 1 ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP+1);
  logic [DW-1:0] mem [DP];
  logic [PW-1:0] wptr, rptr;
  logic push, pop;
  assign i_rdy = cnt != CW'(DP);
  assign o_vld = cnt != '0;
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;
  assign o_dat = (MSKO && !o_vld) ? '0 : mem[rptr];
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DP-1) ? '0 : p + PW'(1);
  endfunction
  // pointers wrap at DP-1 so non-power-of-two depths stay in order; cnt tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= inc(wptr);
      if (pop) rptr <= inc(rptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // storage array is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_dat;
  end
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(DP));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && cnt == '0));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && cnt == CW'(DP)));
endmodule

// File: tb/tb_limber_gnrl_fifo.sv
// tb_limber_gnrl_fifo: queue-model scoreboard over three depth/mask configurations driven in parallel
module tb_limber_gnrl_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_vld = 1'b0;
  logic o_rdy = 1'b0;
  logic [7:0] i_dat = 8'h00;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input int g, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s inst%0d got %0h exp %0h", n, g, a, e);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int D = g == 0 ? 4 : (g == 1 ? 3 : 1);
    localparam int M = g == 2 ? 1 : 0;
    localparam int CW = $clog2(D+1);
    logic i_rdy, o_vld;
    logic [7:0] o_dat;
    logic [CW-1:0] cnt;
    logic [7:0] q [$];
    limber_gnrl_fifo #(.DW(8), .DP(D), .MSKO(M)) dut (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
      .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .cnt(cnt)
    );
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        chk("rst_cnt", g, int'(cnt), 0);
        chk("rst_o_vld", g, int'(o_vld), 0);
        chk("rst_i_rdy", g, int'(i_rdy), 1);
      end else begin
        automatic bit full = q.size() == D;
        automatic bit empty = q.size() == 0;
        chk("cnt", g, int'(cnt), q.size());
        chk("i_rdy", g, int'(i_rdy), int'(!full));
        chk("o_vld", g, int'(o_vld), int'(!empty));
        if (!empty) chk("o_dat", g, int'(o_dat), int'(q[0]));
        if (empty && M == 1) chk("o_dat_mask", g, int'(o_dat), 0);
        if (o_rdy && !empty) void'(q.pop_front());
        if (i_vld && !full) q.push_back(i_dat);
      end
    end
  end
  task automatic step(input logic v, input logic r, input logic [7:0] d);
    @(posedge clk);
    #1;
    i_vld = v;
    o_rdy = r;
    i_dat = d;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    i_vld = 1'b1;
    i_dat = 8'h99;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    i_dat = 8'h11;
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    step(1, 0, 8'h55);
    step(1, 0, 8'h55);
    repeat (6) step(0, 1, 8'h00);
    for (int i = 0; i < 20; i++) step(1, 1, 8'(i));
    repeat (4) step(0, 1, 8'h00);
    step(1, 0, 8'hC0);
    step(1, 0, 8'hC1);
    step(1, 0, 8'hC2);
    step(1, 0, 8'hC3);
    step(1, 1, 8'h66);
    step(1, 1, 8'h77);
    repeat (6) step(0, 1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1, 1'($urandom), 8'hA0 + 8'(i));
      step(1'($urandom), 1'($urandom), 8'hA0 + 8'(i));
    end
    repeat (6) step(0, 1, 8'h00);
    repeat (400) step(1'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));
    step(1, 0, 8'hB1);
    step(1, 0, 8'hB2);
    step(0, 0, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_cnt", 0, int'(gi[0].cnt), 0);
    chk("async_o_vld", 0, int'(gi[0].o_vld), 0);
    chk("async_cnt", 2, int'(gi[2].cnt), 0);
    chk("async_o_dat", 2, int'(gi[2].o_dat), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 1, 8'hE1);
    step(0, 1, 8'h00);
    repeat (3) step(0, 1, 8'h00);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
